// File: rtl/psram_port_arbiter_pkg.sv
// rtl/psram_port_arbiter_pkg.sv - PSRAM address type and arbiter state/helper package
// The byte-address type is shared with the PSRAM controller; the arbiter package holds FSM and round-robin helpers.
package psram_pkg;
  typedef logic [23:0] psram_addr_t;
endpackage

package psram_arb_pkg;
  localparam int MAX_PORTS = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} arb_state_t;

  // First set bit at or after ptr, circularly; unused upper mask bits must be zero.
  function automatic logic [2:0] rr_next(input logic [MAX_PORTS-1:0] mask, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_next = ptr;
    for (int k = MAX_PORTS - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (mask[idx]) rr_next = idx;
    end
  endfunction
endpackage

// File: rtl/psram_port_arbiter_if.sv
// rtl/psram_port_arbiter_if.sv - byte-wide command port between arbiter and PSRAM controller
interface psram_ctrl_if;
  import psram_pkg::*;

  psram_addr_t address;
  logic        read8;
  logic        write8;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        busy;

  modport client (output address, read8, write8, write_data, input read_data, busy);
  modport controller (input address, read8, write8, write_data, output read_data, busy);
endinterface

// File: rtl/psram_port_arbiter_rr_arbiter.sv
// rtl/psram_port_arbiter_rr_arbiter.sv - combinational round-robin grant selection
module rr_arbiter
  import psram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [2:0]           grant_idx
);
  logic [MAX_PORTS-1:0] mask;

  always_comb begin
    mask = '0;
    mask[NUM_PORTS-1:0] = req;
    grant_idx = rr_next(mask, ptr);
    grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = (|req) && (grant_idx == 3'(i));
    end
  end
endmodule

// File: rtl/psram_port_arbiter.sv
// rtl/psram_port_arbiter.sv - multi-client word front end for the byte-wide PSRAM controller
// Grants one client round-robin and splits its word into little-endian byte accesses.
module psram_port_arbiter
  import psram_pkg::*;
  import psram_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_BYTES = 1,
  parameter int ADDR_W     = $bits(psram_addr_t)
) (
  input  logic                            i_CLK,
  input  logic                            i_RST_N,
  input  logic [NUM_PORTS-1:0]            i_req,
  input  logic [NUM_PORTS-1:0]            i_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]     i_addr,
  input  logic [NUM_PORTS*8*DATA_BYTES-1:0] i_wdata,
  output logic [NUM_PORTS-1:0]            o_ack,
  output logic [8*DATA_BYTES-1:0]         o_rdata,
  psram_ctrl_if.client                    ctrl
);
  localparam int WORD_W = 8 * DATA_BYTES;

  arb_state_t           state, state_nxt;
  logic [2:0]           ptr_q, gidx_q, rr_idx;
  logic [NUM_PORTS-1:0] gnt_q, rr_grant;
  logic                 we_q, sel_we, cmd_we, last_byte;
  logic [ADDR_W-1:0]    base_q, sel_addr, cmd_base;
  logic [WORD_W-1:0]    wdata_q, sel_wdata, cmd_word, rdata_q, rdata_upd;
  logic [1:0]           idx_q, cmd_idx;
  logic [7:0]           cmd_byte;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req       (i_req),
    .ptr       (ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  assign last_byte = (int'(idx_q) == DATA_BYTES - 1);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (|i_req && !ctrl.busy) state_nxt = ISSUE;
      ISSUE:      state_nxt = WAIT_START;
      WAIT_START: if (ctrl.busy) state_nxt = WAIT_DONE;
      WAIT_DONE:  if (!ctrl.busy) state_nxt = last_byte ? IDLE : ISSUE;
      default:    state_nxt = IDLE;
    endcase
  end

  // The first byte's command is built straight from the granted port's inputs, later bytes from the latched word.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rr_grant[i]) begin
        sel_we    = i_we[i];
        sel_addr  = i_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = i_wdata[i*WORD_W +: WORD_W];
      end
    end
    cmd_we   = we_q;
    cmd_base = base_q;
    cmd_word = wdata_q;
    cmd_idx  = idx_q + 2'd1;
    if (state == IDLE) begin
      cmd_we   = sel_we;
      cmd_base = sel_addr;
      cmd_word = sel_wdata;
      cmd_idx  = 2'd0;
    end
    cmd_byte  = '0;
    rdata_upd = rdata_q;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (int'(cmd_idx) == b) cmd_byte = cmd_word[8*b +: 8];
      if (int'(idx_q) == b) rdata_upd[8*b +: 8] = ctrl.read_data;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state           <= IDLE;
      ptr_q           <= '0;
      gidx_q          <= '0;
      gnt_q           <= '0;
      we_q            <= 1'b0;
      base_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      idx_q           <= '0;
      o_ack           <= '0;
      o_rdata         <= '0;
      ctrl.read8      <= 1'b0;
      ctrl.write8     <= 1'b0;
      ctrl.address    <= '0;
      ctrl.write_data <= '0;
    end else begin
      state       <= state_nxt;
      o_ack       <= '0;
      ctrl.read8  <= 1'b0;
      ctrl.write8 <= 1'b0;
      if (state_nxt == ISSUE) begin
        ctrl.read8      <= !cmd_we;
        ctrl.write8     <= cmd_we;
        ctrl.address    <= psram_addr_t'(cmd_base + ADDR_W'(cmd_idx));
        ctrl.write_data <= cmd_byte;
        idx_q           <= cmd_idx;
        if (state == IDLE) begin
          gnt_q   <= rr_grant;
          gidx_q  <= rr_idx;
          we_q    <= sel_we;
          base_q  <= sel_addr;
          wdata_q <= sel_wdata;
        end
      end
      if (state == WAIT_DONE && !ctrl.busy) begin
        if (!we_q) rdata_q <= rdata_upd;
        if (last_byte) begin
          o_ack <= gnt_q;
          if (!we_q) o_rdata <= rdata_upd;
          ptr_q <= (gidx_q == 3'(NUM_PORTS - 1)) ? 3'd0 : gidx_q + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_psram_port_arbiter.sv
// tb/tb_psram_port_arbiter.sv - randomized self-checking bench for psram_port_arbiter
// A behavioural PSRAM controller plus a round-robin word-order model predict every strobe and ack.
module tb_psram_port_arbiter;
  import psram_pkg::*;

  localparam int NP = 3;
  localparam int DB = 4;
  localparam int AW = $bits(psram_addr_t);
  localparam int WW = 8 * DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] we = '0;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*WW-1:0] wdata = '0;
  logic [NP-1:0] ack;
  logic [WW-1:0] rdata;

  psram_ctrl_if bus ();

  psram_port_arbiter #(.NUM_PORTS(NP), .DATA_BYTES(DB), .ADDR_W(AW)) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .i_req   (req),
    .i_we    (we),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_ack   (ack),
    .o_rdata (rdata),
    .ctrl    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Untouched locations read back a fixed address-derived pattern.
  function automatic logic [7:0] init_byte(input psram_addr_t a);
    if (a == 24'h10) return 8'hA5;
    if (a == 24'h11) return 8'h3C;
    return a[7:0] * 8'd13 + 8'h5A;
  endfunction

  logic [7:0] mem [psram_addr_t];
  logic [7:0] ref_mem [psram_addr_t];

  function automatic logic [7:0] mem_rd(input psram_addr_t a);
    return mem.exists(a) ? mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input psram_addr_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  logic       model_busy = 1'b0;
  logic       busy_hold  = 1'b0;
  logic [7:0] model_rd   = '0;
  int         lat_fixed  = 0;

  assign bus.busy      = model_busy | busy_hold;
  assign bus.read_data = model_rd;

  initial begin : controller_model
    psram_addr_t a;
    int l;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (bus.read8 || bus.write8)) begin
        a = bus.address;
        if (bus.write8) mem[a] = bus.write_data;
        l = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
        @(posedge clk);
        #1;
        model_busy = 1'b1;
        model_rd   = mem_rd(a);
        repeat (l) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  logic          w_we   [NP];
  psram_addr_t   w_addr [NP];
  logic [WW-1:0] w_data [NP];
  int            left   [NP];
  int            rr_start = 0;

  task automatic load_word(input int p, input logic fwe, input psram_addr_t fa, input logic [WW-1:0] fd);
    w_we[p]   = fwe;
    w_addr[p] = fa;
    w_data[p] = fd;
    we[p]     = fwe;
    addr[p*AW +: AW]  = fa;
    wdata[p*WW +: WW] = fd;
  endtask

  task automatic rand_word(input int p);
    psram_addr_t a;
    if ($urandom_range(0, 7) == 0) a = psram_addr_t'((1 << AW) - int'($urandom_range(1, 3)));
    else a = psram_addr_t'($urandom_range(0, 63));
    load_word(p, 1'($urandom_range(0, 1)), a, WW'($urandom));
  endtask

  // Every port in mask issues `rounds` words and keeps requesting until its last one is acked.
  task automatic run_words(input logic [NP-1:0] mask, input int rounds, input int exp_lat);
    int order[$];
    int p, last, bytes_seen, cyc, first_ack;
    psram_addr_t ba;
    logic [WW-1:0] exp_rd;
    last = 0;
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < NP; k++) begin
        p = (rr_start + k) % NP;
        if (mask[p]) begin
          order.push_back(p);
          last = p;
        end
      end
    end
    rr_start = (last + 1) % NP;
    for (int i = 0; i < NP; i++) left[i] = mask[i] ? rounds : 0;
    @(posedge clk);
    #1 req = mask;
    cyc = 0;
    bytes_seen = 0;
    first_ack = -1;
    while (order.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      if (bus.read8 || bus.write8) begin
        p  = order[0];
        ba = psram_addr_t'(w_addr[p] + bytes_seen);
        check_eq("strobe_busy", bus.busy, 0);
        check_eq("strobe_kind", {bus.write8, bus.read8}, w_we[p] ? 2'b10 : 2'b01);
        check_eq("strobe_addr", bus.address, ba);
        if (w_we[p]) check_eq("strobe_wdata", bus.write_data, w_data[p][8*bytes_seen +: 8]);
        bytes_seen++;
      end
      if (ack != '0) begin
        p = order.pop_front();
        check_eq("ack_port", ack, 64'(1) << p);
        check_eq("ack_bytes", bytes_seen, DB);
        if (first_ack < 0) first_ack = cyc;
        for (int b = 0; b < DB; b++) begin
          ba = psram_addr_t'(w_addr[p] + b);
          if (w_we[p]) begin
            ref_mem[ba] = w_data[p][8*b +: 8];
            check_eq("mem_write", mem_rd(ba), w_data[p][8*b +: 8]);
          end else begin
            exp_rd[8*b +: 8] = ref_rd(ba);
          end
        end
        if (!w_we[p]) check_eq("rdata", rdata, exp_rd);
        bytes_seen = 0;
        left[p]--;
        if (left[p] > 0) rand_word(p);
        else req[p] = 1'b0;
      end
      cyc++;
    end
    check_eq("words_done", order.size(), 0);
    if (exp_lat > 0) check_eq("ack_latency", first_ack, exp_lat);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ack"}, ack, 0);
    check_eq({tag, "_rdata"}, rdata, 0);
    check_eq({tag, "_strobes"}, {bus.read8, bus.write8}, 0);
    check_eq({tag, "_address"}, bus.address, 0);
    check_eq({tag, "_wdata"}, bus.write_data, 0);
  endtask

  initial begin : main
    logic [NP-1:0] m;
    int n, guard;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    lat_fixed = 3;
    load_word(0, 1'b0, 24'h10, '0);
    run_words(3'b001, 1, DB * (3 + 2) + 1);
    check_eq("rdata_lo", rdata[15:0], 16'h3CA5);

    load_word(1, 1'b1, 24'h100, 32'hDEADBEEF);
    run_words(3'b010, 1, 0);
    check_eq("wr_b0", mem_rd(24'h100), 8'hEF);
    check_eq("wr_b1", mem_rd(24'h101), 8'hBE);
    check_eq("wr_b2", mem_rd(24'h102), 8'hAD);
    check_eq("wr_b3", mem_rd(24'h103), 8'hDE);

    load_word(2, 1'b0, '1, '0);
    run_words(3'b100, 1, 0);

    lat_fixed = 0;
    for (int i = 0; i < NP; i++) rand_word(i);
    run_words(3'b111, 2, 0);

    repeat (25) begin
      m = NP'($urandom_range(1, (1 << NP) - 1));
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < NP; i++) if (m[i]) rand_word(i);
      run_words(m, n, 0);
    end

    // A busy controller holds off the first strobe until one cycle after busy drops.
    rand_word(1);
    @(posedge clk);
    #1;
    busy_hold = 1'b1;
    req[1] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_eq("busy_no_strobe", bus.read8 | bus.write8, 0);
    end
    @(posedge clk);
    #1 busy_hold = 1'b0;
    @(negedge clk);
    check_eq("busy_fall_no_strobe", bus.read8 | bus.write8, 0);
    @(negedge clk);
    check_eq("strobe_after_busy", bus.read8 | bus.write8, 1);
    guard = 0;
    while (ack == '0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("busy_word_ack", ack, 3'b010);
    if (w_we[1]) for (int b = 0; b < DB; b++) ref_mem[psram_addr_t'(w_addr[1] + b)] = w_data[1][8*b +: 8];
    req[1] = 1'b0;
    rr_start = 2;

    // Reset in the middle of byte 1 of a four-byte read.
    lat_fixed = 4;
    load_word(1, 1'b0, 24'h20, '0);
    @(posedge clk);
    #1 req = 3'b010;
    n = 0;
    guard = 0;
    while (n < 2 && guard < 200) begin
      @(negedge clk);
      if (bus.read8 || bus.write8) n++;
      guard++;
    end
    check_eq("reset_setup_strobes", n, 2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    req = '0;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_no_ack", ack, 0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_reset_no_ack", ack, 0);
    end
    rr_start = 0;
    lat_fixed = 0;
    for (int i = 0; i < NP; i++) rand_word(i);
    run_words(3'b111, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/psram_port_arbiter.md
# psram_port_arbiter

Parametrised multi-client front end for the PSRAM controller. It accepts word-wide read/write requests from `NUM_PORTS` independent clients and arbitrates them round-robin. Each word is split into sequential byte accesses on the controller's byte-wide `psram_ctrl_if.client` port, and the assembled read word is returned to the requester. It sits between the MGS/PICO bus-side logic and the single PSRAM controller instance.

## Interface
- `NUM_PORTS`, 2: number of client ports, 1..8.
- `DATA_BYTES`, 1: bytes per client word, 1..4; the word width is `8*DATA_BYTES`.
- `ADDR_W`, `$bits(psram_addr_t)`: byte-address width.
- `i_CLK` in 1: system clock, the same clock as the PSRAM controller host side.
- `i_RST_N` in 1: asynchronous, active-low reset.
- `i_req` in `NUM_PORTS`: per-port request level. It is held until the matching `o_ack`.
- `i_we` in `NUM_PORTS`: per-port write enable (1 = write, 0 = read). Stable while `i_req` is high.
- `i_addr` in `NUM_PORTS*ADDR_W`: per-port byte address of the word's lowest byte. Stable while `i_req` is high.
- `i_wdata` in `NUM_PORTS*8*DATA_BYTES`: per-port write word. Stable while `i_req` is high.
- `o_ack` out `NUM_PORTS`: one-cycle completion pulse per port.
- `o_rdata` out `8*DATA_BYTES`: read word. Valid only in the cycle the granted port's `o_ack` is high.
- `ctrl` modport `psram_ctrl_if.client`: drives `address`, `read8`, `write8` and `write_data`; samples `read_data` and `busy`.

## Operation
- The state machine has four states: IDLE, ISSUE, WAIT_START and WAIT_DONE.
- IDLE:
  - If any `i_req` is high, grant one port round-robin. The search starts at the port after the last granted port; after reset it starts at port 0.
  - On a grant, latch that port's `i_we`, `i_addr` and `i_wdata`, clear the byte index, and go to ISSUE.
- ISSUE:
  - Drive `address = base + idx`, with the sum taken modulo `2^ADDR_W` so the address wraps at the top.
  - Drive `write_data = wdata[8*idx +: 8]`.
  - Raise `read8` or `write8` for exactly one cycle, then go to WAIT_START.
- WAIT_START: stay until `busy` = 1, then go to WAIT_DONE.
- WAIT_DONE: stay until `busy` = 0. Then:
  - For a read, store `read_data` into `rdata[8*idx +: 8]`. Byte ordering is little-endian: byte 0 comes from the lowest address.
  - If `idx < DATA_BYTES-1`, increment `idx` and go to ISSUE.
  - Otherwise pulse `o_ack[grant]`, present `o_rdata`, update the round-robin pointer, and go to IDLE.
- A word is never interleaved with another port's bytes. The grant is held for all `DATA_BYTES` accesses.
- For write acks, `o_rdata` holds its previous value. Its content is don't-care.
- A request that drops before its ack is a client protocol error. The arbiter still completes the latched word and still pulses the ack.
- The arbiter never issues a command while `busy` is high.

## Timing
- Every output is registered.
- Reset values: `o_ack` = 0, `o_rdata` = 0, `read8` = 0, `write8` = 0, `address` = 0, `write_data` = 0. The state is IDLE, the round-robin pointer is 0, and the byte index is 0.
- Reset mid-operation:
  - All outputs take their reset values immediately, asynchronously.
  - Any in-flight controller access is abandoned and no ack is produced.
  - Clients must re-request after reset.
- Latency per word, from `i_req` sampled high in IDLE at cycle n:
  - Strobe is high at n+1.
  - With the controller busy for L cycles (n+2 .. n+1+L), the byte is captured at n+2+L.
  - The next byte's strobe is at n+3+L.
  - `o_ack` is high at n+3+L for the last byte.
  - Total ack latency = `DATA_BYTES*(L+2) + 1` cycles.
- The earliest new grant is in the cycle after `o_ack`, i.e. one idle cycle between words.
- If `o_ack[p]` and a new `i_req[p]` coincide, the new request is accepted at the next IDLE. Round-robin fairness still applies, so other pending ports go first.
- Starvation bound: a pending port is granted within `NUM_PORTS-1` other words.

## Structure
- `psram_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE/ISSUE/WAIT_START/WAIT_DONE);
  - the helper function `rr_next(mask, ptr)`.
- The address type `psram_addr_t` stays in its existing package.
- Sub-module `rr_arbiter`, parametrised by `NUM_PORTS`:
  - inputs: request mask, last-grant pointer;
  - outputs: one-hot grant and encoded index;
  - purely combinational;
  - the pointer register lives in the top level.

## Test plan
- **Single read, `DATA_BYTES`=2, L=3:** port 0 reads 0x0010 with the memory model holding 0x10=0xA5 and 0x11=0x3C. Expected:
  - strobes at 0x0010 then 0x0011;
  - `o_ack[0]` at cycle n+11;
  - `o_rdata` = 0x3CA5.
- **Write, `DATA_BYTES`=4:** port 1 writes 0xDEADBEEF to 0x0100. Expected:
  - write8 sequence EF,BE,AD,DE at 0x100..0x103;
  - one `o_ack[1]` pulse;
  - memory model matches.
- **Round-robin, `NUM_PORTS`=3:** all ports hold `i_req` continuously. Expected:
  - grant order 0,1,2,0,1,2;
  - no port granted twice before the others.
- **Address wrap:** `DATA_BYTES`=2, read at `2^ADDR_W-1`. Expected: second byte addressed at 0.
- **Reset mid-word:** assert `i_RST_N`=0 during WAIT_DONE of byte 1 of 4. Expected:
  - all outputs 0 in the same cycle;
  - no ack;
  - after release the first grant goes to port 0.
- **Busy respect:** hold `busy` = 1 for 20 cycles before the first access. Expected: no strobe while busy is high; the first strobe comes one cycle after busy falls.
